controlador_coprocessador: RTL and testbench

//  Host-side command front end of the matrix arithmetic unit: accepts 32-bit instruction words,

---
 rtl/controlador_coprocessador_pkg.sv | 44 ++++
 rtl/controlador_coprocessador_if.sv | 24 ++
 rtl/controlador_coprocessador_elem_access.sv | 30 +++
 rtl/controlador_coprocessador.sv | 168 ++++++++++++++++
 tb/tb_controlador_coprocessador.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/controlador_coprocessador_pkg.sv
// Shared definitions for the matrix coprocessor command front end: instruction
// field layout, command/op codes, element geometry and controller state encoding.
package coproc_pkg;

    localparam int N_ELEM = 25;
    localparam int ELEM_W = 9;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 5;
    localparam int MAT_W  = N_ELEM * ELEM_W;

    localparam int CMD_LSB  = 0;
    localparam int SEL_BIT  = 3;
    localparam int OP_LSB   = 4;
    localparam int IDX_LSB  = 8;
    localparam int DATA_LSB = 16;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'b000,
        CMD_LOAD  = 3'b001,
        CMD_EXEC  = 3'b010,
        CMD_READ  = 3'b011,
        CMD_CLEAR = 3'b100
    } cmd_e;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_TRANSP = 3'b011;
    localparam logic [2:0] OP_OPP    = 3'b100;
    localparam logic [2:0] OP_DET    = 3'b101;
    localparam logic [2:0] OP_SCALAR = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return idx < IDX_W'(N_ELEM);
    endfunction

endpackage

// File: rtl/controlador_coprocessador_if.sv
// Host-side instruction/response bundle between the bus bridge (master) and
// the coprocessor controller (slave).
interface controlador_coprocessador_if;
    import coproc_pkg::*;

    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [ELEM_W-1:0] rsp_data;
    logic              rsp_valid;
    logic              busy;
    logic              error;

    modport master (
        output instr, instr_valid,
        input  instr_ready, rsp_data, rsp_valid, busy, error
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, rsp_data, rsp_valid, busy, error
    );

endinterface

// File: rtl/controlador_coprocessador_elem_access.sv
// Combinational access to one 9-bit slot of a packed 25-element vector:
// returns the slot (0 if idx out of range) and a copy of the vector with it replaced.
module elem_access
    import coproc_pkg::*;
(
    input  logic [MAT_W-1:0]  vec,
    input  logic [IDX_W-1:0]  idx,
    input  logic [ELEM_W-1:0] wdata,
    output logic [ELEM_W-1:0] rdata,
    output logic [MAT_W-1:0]  wvec
);

    logic [ELEM_W-1:0] slot_rd [N_ELEM];

    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_slot
        logic hit;
        assign hit = (idx == IDX_W'(gi));
        assign wvec[gi*ELEM_W +: ELEM_W] = hit ? wdata : vec[gi*ELEM_W +: ELEM_W];
        assign slot_rd[gi] = hit ? vec[gi*ELEM_W +: ELEM_W] : '0;
    end

    // At most one slot is selected, so an OR-reduction acts as the read mux.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            rdata = rdata | slot_rd[i];
        end
    end

endmodule

// File: rtl/controlador_coprocessador.sv
// Command front end of the matrix arithmetic unit: operand packing, EXEC handshake
// with done timeout, result readback. Define CTRL_OP_COUNTER_EN to add the ops_done counter.
module controlador_coprocessador
    import coproc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic                 clk,
    input  logic                 rst_n,
    controlador_coprocessador_if.slave host,
    output logic                 alu_start,
    output logic [2:0]           alu_op,
    output logic [MAT_W-1:0]     alu_mat_a,
    output logic [MAT_W-1:0]     alu_mat_b,
    input  logic [MAT_W-1:0]     alu_result,
    input  logic                 alu_done
`ifdef CTRL_OP_COUNTER_EN
    ,
    output logic [15:0]          ops_done
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [MAT_W-1:0]  mat_a_q, mat_a_d, mat_b_q, mat_b_d, result_q, result_d;
    logic [2:0]        op_q, op_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              error_q, error_d;
`ifdef CTRL_OP_COUNTER_EN
    logic [15:0]       ops_q, ops_d;
`endif

    cmd_e              cmd;
    logic              sel;
    logic [IDX_W-1:0]  instr_idx;
    logic              accept;
    logic [MAT_W-1:0]  ea_vec, ea_wvec;
    logic [IDX_W-1:0]  ea_idx;
    logic [ELEM_W-1:0] ea_rdata;

    assign cmd       = cmd_e'(host.instr[CMD_LSB +: 3]);
    assign sel       = host.instr[SEL_BIT];
    assign instr_idx = host.instr[IDX_LSB +: IDX_W];
    assign accept    = host.instr_valid && (state_q == ST_IDLE);

    // One accessor serves both paths: LOAD writes happen only in IDLE, READ only in RESP.
    assign ea_vec = (state_q == ST_RESP) ? result_q : (sel ? mat_b_q : mat_a_q);
    assign ea_idx = (state_q == ST_RESP) ? idx_q : instr_idx;

    elem_access u_elem_access (
        .vec   (ea_vec),
        .idx   (ea_idx),
        .wdata ({1'b0, host.instr[DATA_LSB +: DATA_W]}),
        .rdata (ea_rdata),
        .wvec  (ea_wvec)
    );

    always_comb begin
        state_d  = state_q;
        mat_a_d  = mat_a_q;
        mat_b_d  = mat_b_q;
        result_d = result_q;
        op_d     = op_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        error_d  = error_q;
`ifdef CTRL_OP_COUNTER_EN
        ops_d    = ops_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd)
                        CMD_LOAD: begin
                            if (sel) mat_b_d = ea_wvec;
                            else     mat_a_d = ea_wvec;
                            if (!idx_in_range(instr_idx)) error_d = 1'b1;
                        end
                        CMD_EXEC: begin
                            op_d    = host.instr[OP_LSB +: 3];
                            state_d = ST_ISSUE;
                        end
                        CMD_READ: begin
                            idx_d   = instr_idx;
                            state_d = ST_RESP;
                            if (!idx_in_range(instr_idx)) error_d = 1'b1;
                        end
                        CMD_CLEAR: begin
                            mat_a_d  = '0;
                            mat_b_d  = '0;
                            result_d = '0;
                            error_d  = 1'b0;
`ifdef CTRL_OP_COUNTER_EN
                            ops_d    = '0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_done) begin
                    result_d = alu_result;
                    state_d  = ST_IDLE;
`ifdef CTRL_OP_COUNTER_EN
                    ops_d    = ops_q + 16'd1;
`endif
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mat_a_q  <= '0;
            mat_b_q  <= '0;
            result_q <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
`ifdef CTRL_OP_COUNTER_EN
            ops_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mat_a_q  <= mat_a_d;
            mat_b_q  <= mat_b_d;
            result_q <= result_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
`ifdef CTRL_OP_COUNTER_EN
            ops_q    <= ops_d;
`endif
        end
    end

    // Outputs decode straight from the state flop so reset clears them asynchronously.
    assign host.instr_ready = (state_q == ST_IDLE);
    assign host.busy        = (state_q != ST_IDLE);
    assign host.rsp_valid   = (state_q == ST_RESP);
    assign host.rsp_data    = (state_q == ST_RESP) ? ea_rdata : '0;
    assign host.error       = error_q;
    assign alu_start        = (state_q == ST_ISSUE);
    assign alu_op           = op_q;
    assign alu_mat_a        = mat_a_q;
    assign alu_mat_b        = mat_b_q;
`ifdef CTRL_OP_COUNTER_EN
    assign ops_done         = ops_q;
`endif

endmodule

// File: tb/tb_controlador_coprocessador.sv
// Directed bench for controlador_coprocessador: vector table of instructions with
// hand-computed responses, plus timeout, bad-index and async-reset sequences.
module tb_controlador_coprocessador;
    import coproc_pkg::*;

    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             alu_start;
    logic [2:0]       alu_op;
    logic [MAT_W-1:0] alu_mat_a, alu_mat_b, alu_result;
    logic             alu_done;
    logic             done_en = 1'b1;
`ifdef CTRL_OP_COUNTER_EN
    logic [15:0]      ops_done;
`endif

    int checks = 0;
    int failures = 0;

    controlador_coprocessador_if hif();

    controlador_coprocessador #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host       (hif.slave),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_mat_a  (alu_mat_a),
        .alu_mat_b  (alu_mat_b),
        .alu_result (alu_result),
        .alu_done   (alu_done)
`ifdef CTRL_OP_COUNTER_EN
        ,
        .ops_done   (ops_done)
`endif
    );

    always #5 clk = ~clk;

    // Arithmetic unit stand-in: element-wise add/sub, result registered on the start edge, sticky done.
    function automatic logic [MAT_W-1:0] unit_calc(input logic [MAT_W-1:0] a,
                                                   input logic [MAT_W-1:0] b,
                                                   input logic [2:0] op);
        logic [MAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (op == OP_ADD) r[i*ELEM_W +: ELEM_W] = a[i*ELEM_W +: ELEM_W] + b[i*ELEM_W +: ELEM_W];
            else if (op == OP_SUB) r[i*ELEM_W +: ELEM_W] = a[i*ELEM_W +: ELEM_W] - b[i*ELEM_W +: ELEM_W];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_done   <= 1'b0;
            alu_result <= '0;
        end else if (alu_start) begin
            alu_result <= unit_calc(alu_mat_a, alu_mat_b, alu_op);
            alu_done   <= done_en;
        end
    end

    function automatic logic [31:0] mk(input logic [2:0] cmd, input logic sel, input logic [2:0] op,
                                       input logic [4:0] idx, input logic [7:0] data);
        return {8'h00, data, 3'b000, idx, 1'b0, op, sel, cmd};
    endfunction

    task automatic chk(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one instruction from IDLE, then follow it until busy drops (bounded).
    task automatic send(input logic [31:0] w, output int rsp_cnt, output logic [8:0] rsp,
                        output int busy_cyc);
        @(negedge clk);
        hif.instr = w;
        hif.instr_valid = 1'b1;
        @(negedge clk);
        hif.instr_valid = 1'b0;
        rsp_cnt = 0;
        rsp = '0;
        busy_cyc = 0;
        for (int i = 0; i < 64 && hif.busy; i++) begin
            if (hif.rsp_valid) begin
                rsp_cnt++;
                rsp = hif.rsp_data;
            end
            busy_cyc++;
            @(negedge clk);
        end
        chk("idle_within_bound", MAT_W'(hif.busy), '0);
    endtask

    typedef struct {
        logic [31:0] instr;
        bit          chk_rsp;
        logic [8:0]  exp_rsp;
        logic        exp_err;
        int          exp_busy;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int         rc, bc;
        logic [8:0] rd;
        logic [MAT_W-1:0] exp_a;

        hif.instr = '0;
        hif.instr_valid = 1'b0;

        vecs[0]  = '{mk(CMD_LOAD, 1'b0, 3'd0, 5'd0, 8'd5),    1'b0, 9'd0,   1'b0, -1};
        vecs[1]  = '{mk(CMD_LOAD, 1'b1, 3'd0, 5'd0, 8'd3),    1'b0, 9'd0,   1'b0, -1};
        vecs[2]  = '{mk(CMD_EXEC, 1'b0, OP_ADD, 5'd0, 8'd0),  1'b0, 9'd0,   1'b0, 2};
        vecs[3]  = '{mk(CMD_READ, 1'b0, 3'd0, 5'd0, 8'd0),    1'b1, 9'd8,   1'b0, 1};
        vecs[4]  = '{mk(CMD_LOAD, 1'b0, 3'd0, 5'd24, 8'hFF),  1'b0, 9'd0,   1'b0, -1};
        vecs[5]  = '{mk(CMD_LOAD, 1'b1, 3'd0, 5'd24, 8'h01),  1'b0, 9'd0,   1'b0, -1};
        vecs[6]  = '{mk(CMD_EXEC, 1'b0, OP_SUB, 5'd0, 8'd0),  1'b0, 9'd0,   1'b0, 2};
        vecs[7]  = '{mk(CMD_READ, 1'b0, 3'd0, 5'd24, 8'd0),   1'b1, 9'h0FE, 1'b0, 1};
        vecs[8]  = '{mk(CMD_READ, 1'b0, 3'd0, 5'd0, 8'd0),    1'b1, 9'd2,   1'b0, 1};
        vecs[9]  = '{mk(3'b101, 1'b0, 3'd0, 5'd30, 8'd0),     1'b0, 9'd0,   1'b0, 0};
        vecs[10] = '{mk(CMD_NOP, 1'b0, 3'd0, 5'd0, 8'd0),     1'b0, 9'd0,   1'b0, 0};

        // Reset state while rst_n is held low.
        repeat (3) @(negedge clk);
        chk("rst_instr_ready", MAT_W'(hif.instr_ready), MAT_W'(1));
        chk("rst_busy", MAT_W'(hif.busy), '0);
        chk("rst_rsp_valid", MAT_W'(hif.rsp_valid), '0);
        chk("rst_rsp_data", MAT_W'(hif.rsp_data), '0);
        chk("rst_error", MAT_W'(hif.error), '0);
        chk("rst_alu_start", MAT_W'(alu_start), '0);
        chk("rst_alu_op", MAT_W'(alu_op), '0);
        chk("rst_mat_a", alu_mat_a, '0);
        chk("rst_mat_b", alu_mat_b, '0);
        rst_n = 1'b1;

        for (int v = 0; v < 11; v++) begin
            send(vecs[v].instr, rc, rd, bc);
            chk($sformatf("vec%0d_error", v), MAT_W'(hif.error), MAT_W'(vecs[v].exp_err));
            if (vecs[v].chk_rsp) begin
                chk($sformatf("vec%0d_rsp_data", v), MAT_W'(rd), MAT_W'(vecs[v].exp_rsp));
                chk($sformatf("vec%0d_rsp_count", v), MAT_W'(rc), MAT_W'(1));
            end
            if (vecs[v].exp_busy >= 0)
                chk($sformatf("vec%0d_busy_cycles", v), MAT_W'(bc), MAT_W'(vecs[v].exp_busy));
            $display("vec %0d instr=%08h rsp_cnt=%0d rsp=%0h busy=%0d err=%0b", v, vecs[v].instr, rc, rd, bc, hif.error);
        end
        chk("mat_a_top_slot", MAT_W'(alu_mat_a[224:216]), MAT_W'(9'h0FF));
        chk("mat_b_slot0", MAT_W'(alu_mat_b[8:0]), MAT_W'(9'd3));

        // Timeout: unit never completes; ISSUE plus exactly TIMEOUT WAIT cycles.
        done_en = 1'b0;
        send(mk(CMD_EXEC, 1'b0, OP_ADD, 5'd0, 8'd0), rc, rd, bc);
        $display("timeout exec busy=%0d err=%0b", bc, hif.error);
        chk("timeout_wait_cycles", MAT_W'(bc - 1), MAT_W'(TIMEOUT));
        chk("timeout_error", MAT_W'(hif.error), MAT_W'(1));
        send(mk(CMD_READ, 1'b0, 3'd0, 5'd24, 8'd0), rc, rd, bc);
        $display("read after timeout rsp=%0h", rd);
        chk("timeout_result_kept", MAT_W'(rd), MAT_W'(9'h0FE));
        send(mk(CMD_CLEAR, 1'b0, 3'd0, 5'd0, 8'd0), rc, rd, bc);
        $display("clear err=%0b", hif.error);
        chk("clear_error", MAT_W'(hif.error), '0);
        chk("clear_mat_a", alu_mat_a, '0);
        send(mk(CMD_READ, 1'b0, 3'd0, 5'd24, 8'd0), rc, rd, bc);
        chk("clear_result", MAT_W'(rd), '0);

        // Out-of-range indices.
        send(mk(CMD_LOAD, 1'b0, 3'd0, 5'd3, 8'h11), rc, rd, bc);
        exp_a = '0;
        exp_a[27 +: 9] = 9'h011;
        send(mk(CMD_LOAD, 1'b0, 3'd0, 5'd25, 8'h77), rc, rd, bc);
        $display("load idx25 err=%0b", hif.error);
        chk("load_idx25_error", MAT_W'(hif.error), MAT_W'(1));
        chk("load_idx25_mat_a", alu_mat_a, exp_a);
        send(mk(CMD_READ, 1'b0, 3'd0, 5'd31, 8'd0), rc, rd, bc);
        $display("read idx31 rsp_cnt=%0d rsp=%0h", rc, rd);
        chk("read_idx31_data", MAT_W'(rd), '0);
        chk("read_idx31_count", MAT_W'(rc), MAT_W'(1));
        send(mk(CMD_CLEAR, 1'b0, 3'd0, 5'd0, 8'd0), rc, rd, bc);
        chk("clear2_error", MAT_W'(hif.error), '0);

        // Async reset during ISSUE and during WAIT.
        @(negedge clk);
        hif.instr = mk(CMD_EXEC, 1'b0, OP_ADD, 5'd0, 8'd0);
        hif.instr_valid = 1'b1;
        @(negedge clk);
        hif.instr_valid = 1'b0;
        chk("issue_alu_start", MAT_W'(alu_start), MAT_W'(1));
        #1 rst_n = 1'b0;
        #1 chk("issue_rst_alu_start", MAT_W'(alu_start), '0);
        chk("issue_rst_busy", MAT_W'(hif.busy), '0);
        $display("reset in ISSUE start=%0b busy=%0b", alu_start, hif.busy);
        @(negedge clk);
        rst_n = 1'b1;
        hif.instr = mk(CMD_EXEC, 1'b0, OP_ADD, 5'd0, 8'd0);
        hif.instr_valid = 1'b1;
        @(negedge clk);
        hif.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wait_busy", MAT_W'(hif.busy), MAT_W'(1));
        #2 rst_n = 1'b0;
        #1 chk("wait_rst_busy", MAT_W'(hif.busy), '0);
        chk("wait_rst_alu_start", MAT_W'(alu_start), '0);
        chk("wait_rst_ready", MAT_W'(hif.instr_ready), MAT_W'(1));
        $display("reset in WAIT start=%0b busy=%0b ready=%0b", alu_start, hif.busy, hif.instr_ready);
        @(negedge clk);
        rst_n = 1'b1;
        done_en = 1'b1;

        // Back-to-back EXECs after release.
        send(mk(CMD_LOAD, 1'b0, 3'd0, 5'd0, 8'd7), rc, rd, bc);
        send(mk(CMD_LOAD, 1'b1, 3'd0, 5'd0, 8'd2), rc, rd, bc);
        send(mk(CMD_EXEC, 1'b0, OP_ADD, 5'd0, 8'd0), rc, rd, bc);
        chk("b2b_exec1_busy", MAT_W'(bc), MAT_W'(2));
        send(mk(CMD_EXEC, 1'b0, OP_SUB, 5'd0, 8'd0), rc, rd, bc);
        chk("b2b_exec2_busy", MAT_W'(bc), MAT_W'(2));
        send(mk(CMD_READ, 1'b0, 3'd0, 5'd0, 8'd0), rc, rd, bc);
        $display("b2b read rsp=%0h err=%0b", rd, hif.error);
        chk("b2b_result", MAT_W'(rd), MAT_W'(9'd5));
        chk("b2b_error", MAT_W'(hif.error), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
